fb_writer: RTL and testbench
============================

# fb_writer

Framebuffer write-side controller: consumes the pixel stream (`X`, `Y`, `Colour`, plot strobe) produced by the drawing datapaths and commits it to a single-port 320x240 15-bit framebuffer RAM. Shares the RAM port with the VGA scanout reader, which always has priority. Provides a bounded write FIFO with backpressure, coordinate clipping, and an optional full-screen hardware clear engine.

## Interface
- `FIFO_DEPTH`, 4: pixel FIFO entries (power of two, at least 2)
- `COLOUR_W`, 15: pixel colour width
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `plot`  in  1  pixel write request, sampled each cycle
- `X`  in  9  pixel column
- `Y`  in  8  pixel row
- `Colour`  in  15  pixel colour
- `ready`  out  1  FIFO not full; `plot` is accepted only when high
- `rd_req`  in  1  scanout read request; highest priority
- `rd_addr`  in  17  scanout linear address
- `rd_valid`  out  1  `mem_rdata` is valid for the previous cycle's `rd_req`
- `rd_data`  out  15  registered copy of `mem_rdata`
- `mem_addr`  out  17  RAM address
- `mem_wdata`  out  15  RAM write data
- `mem_we`  out  1  RAM write enable
- `mem_rdata`  in  15  RAM read data, 1-cycle synchronous latency
- `clear_req`  in  1  start a clear (FB_CLEAR_EN only)
- `clear_colour`  in  15  fill colour, latched when `clear_req` is accepted
- `clear_busy`  out  1  clear in progress
- `clear_done`  out  1  one-cycle pulse after the last clear write
- `clip_cnt`  out  16  saturating count of discarded out-of-range pixels
- `drop_cnt`  out  16  saturating count of `plot` asserted while `ready` is low

## Operation
- **Push:** on `plot && ready`:
  - If `X >= 320` or `Y >= 240`, the pixel is not stored and `clip_cnt` increments.
  - Otherwise {addr, Colour} is pushed, with addr = Y*320 + X = (Y<<8) + (Y<<6) + X, computed at 17 bits with no overflow.
- **Drop:** `plot && !ready` → pixel lost, `drop_cnt` increments. Both counters saturate at 0xFFFF.
- **RAM port arbitration per cycle** (fixed priority, exactly one owner):
  1. `rd_req`: `mem_addr` = `rd_addr`, `mem_we` = 0.
  2. Clear engine when `clear_busy`: write `clear_colour` at `clr_addr`, then `clr_addr` increments.
  3. FIFO non-empty: pop the head and write it.
  4. Idle: `mem_we` = 0, `mem_addr` holds its last value.
- **State machine:** IDLE, DRAIN, CLEAR.
  - IDLE → DRAIN when the FIFO is non-empty.
  - DRAIN → IDLE when the FIFO is empty.
  - IDLE or DRAIN → CLEAR on `clear_req`.
  - CLEAR → IDLE or DRAIN after address 76799 is written.
- **During CLEAR:**
  - The FIFO still accepts pushes but does not drain, so draw-after-clear ordering is preserved.
  - `clear_req` is ignored.
- **Pop/push in the same cycle:** legal. Occupancy is unchanged.
- **`ready`** = !full, taken from the registered occupancy. There is no same-cycle bypass: a full FIFO popping this cycle still shows `ready` = 0.

## Timing
- **Reset values:**
  - `ready` = 1.
  - `mem_we`, `rd_valid`, `clear_busy` and `clear_done` = 0.
  - `mem_addr`, `mem_wdata`, `rd_data`, `clip_cnt` and `drop_cnt` = 0.
  - FIFO empty, state IDLE, `clr_addr` = 0.
- **Write latency:** pixel accepted at cycle t → earliest `mem_we` at t+1, provided no `rd_req` at t+1.
- **Read:** `rd_req` at t → `mem_addr` driven combinationally at t → `rd_valid` = 1 and `rd_data` valid at t+1.
- **`mem_addr`, `mem_wdata`, `mem_we`** are combinational from registered state and `rd_req`.
- **Clear duration:** exactly 76800 write cycles plus the number of cycles stolen by `rd_req`. `clear_busy` rises the cycle after `clear_req` is accepted.
- **`clear_done`:** high for exactly the one cycle after the last write. `clear_busy` is low in that same cycle.
- **Reset mid-operation:** reset asserted during a clear or a drain aborts it. The FIFO is flushed and all outputs return to their reset values on the next edge. Pixels not yet written are lost.

## Configuration
- **`FB_CLEAR_EN` defined:** the clear engine and CLEAR state are built as described above.
- **`FB_CLEAR_EN` undefined:**
  - No clear logic is built; `clear_req` and `clear_colour` are ignored.
  - `clear_busy` and `clear_done` are tied to 0.
  - Arbitration is `rd_req` first, then FIFO.

## Structure
- **Package `fb_pkg`:**
  - FB_W = 320, FB_H = 240, FB_PIXELS = 76800, FB_AW = 17.
  - State enum {IDLE, DRAIN, CLEAR}.
  - Pixel entry typedef {addr[16:0], colour[14:0]}.
- **Sub-module `pixel_fifo`:** synchronous, parameterised depth.
  - Ports: push, pop, din, dout, full, empty.
  - Registered read/write pointers with one extra wrap bit.

## Test plan
- **Simple write:** reset, then `plot` X=5 Y=2 Colour=0x7FFF → one `mem_we` at `mem_addr`=645, `mem_wdata`=0x7FFF, next cycle.
- **Clipping:** `plot` X=320 Y=0, then X=0 Y=240 → no `mem_we`, `clip_cnt`=2; X=319 Y=239 → write at address 76799.
- **Backpressure:** hold `rd_req` high and push 6 pixels with FIFO_DEPTH=4 → `ready` falls after the 4th, `drop_cnt`=2; release `rd_req` → 4 writes in push order on consecutive cycles.
- **Read priority:** `rd_req` with `rd_addr`=1000 on the same cycle the FIFO has a pending pixel → `mem_we`=0, `rd_valid` next cycle with `rd_data` = RAM[1000]; the pixel is written one cycle later.
- **Clear (FB_CLEAR_EN):** `clear_req` with colour 0x001F and no reads → 76800 writes of 0x001F, `clear_done` pulse at cycle 76801; a pixel pushed mid-clear is written after `clear_done`.
- **Reset mid-clear:** reset at write 1000 → `clear_busy`=0 and FIFO empty next cycle, no further `mem_we`.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry, controller state encoding, FIFO entry
// layout and the pixel address helper used by the framebuffer write side.
// No ports. Imported by pixel_fifo and fb_writer.
package fb_pkg;

   localparam int FB_W      = 320;
   localparam int FB_H      = 240;
   localparam int FB_PIXELS = 76800;
   localparam int FB_AW     = 17;
   localparam int FB_CW     = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } fb_state_t;

   typedef struct packed {
      logic [FB_AW-1:0] addr;
      logic [FB_CW-1:0] colour;
   } pixel_t;

   // Linear address Y*320 + X as two shifts and an add; the largest value
   // (239*320 + 511) still fits in 17 bits.
   function automatic logic [FB_AW-1:0] pixel_addr(input logic [8:0] x,
                                                   input logic [7:0] y);
      logic [FB_AW-1:0] yy;
      yy = {9'd0, y};
      return (yy << 8) + (yy << 6) + {8'd0, x};
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO for pending pixel writes.
// Ports:
//   clk, reset     clock, synchronous active-high reset (flushes the FIFO)
//   push, din      write din when push is high (caller guarantees !full)
//   pop, dout      dout is the head entry; pop advances it (caller guarantees !empty)
//   full, empty    status decoded from the registered pointers
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module pixel_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/fb_writer.sv
// fb_writer: framebuffer write-side controller. Buffers the pixel stream in a
// small FIFO, clips off-screen pixels, and commits pixels to a single-port
// 320x240 RAM shared with the scanout reader (reads always win).
// Optional full-screen clear engine, built only when FB_CLEAR_EN is defined.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   plot, X, Y, Colour, ready        pixel input stream
//   rd_req, rd_addr                  scanout read request (highest priority)
//   rd_valid, rd_data                read response, one cycle after rd_req
//   mem_addr, mem_wdata, mem_we      RAM port (combinational from state + rd_req)
//   mem_rdata                        RAM read data, 1-cycle latency
//   clear_req, clear_colour          clear start and fill colour
//   clear_busy, clear_done           clear in progress / one-cycle done pulse
//   clip_cnt, drop_cnt               saturating discard counters
//   dbg_state                        controller state for observation
// Handshake: a pixel is transferred on a cycle where plot && ready; ready is
// !full from registered occupancy only, and plot while !ready loses the pixel.
module fb_writer
   import fb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int COLOUR_W   = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                plot,
   input  logic [8:0]          X,
   input  logic [7:0]          Y,
   input  logic [COLOUR_W-1:0] Colour,
   output logic                ready,
   input  logic                rd_req,
   input  logic [FB_AW-1:0]    rd_addr,
   output logic                rd_valid,
   output logic [COLOUR_W-1:0] rd_data,
   output logic [FB_AW-1:0]    mem_addr,
   output logic [COLOUR_W-1:0] mem_wdata,
   output logic                mem_we,
   input  logic [COLOUR_W-1:0] mem_rdata,
   input  logic                clear_req,
   input  logic [COLOUR_W-1:0] clear_colour,
   output logic                clear_busy,
   output logic                clear_done,
   output logic [15:0]         clip_cnt,
   output logic [15:0]         drop_cnt,
   output fb_state_t           dbg_state
);

   localparam int EW = FB_AW + COLOUR_W;

   fb_state_t           state;
   logic                full, empty;
   logic [EW-1:0]       head;
   logic                in_range, accept, push, pop;
   logic                clearing, clr_wr, start_clear;
   logic [FB_AW-1:0]    clr_addr;
   logic [COLOUR_W-1:0] clr_colour;
   logic [FB_AW-1:0]    addr_q;
   logic [COLOUR_W-1:0] wdata_q;
   logic [COLOUR_W-1:0] rd_data_q;

   assign ready     = !full;
   assign in_range  = (X < 9'(FB_W)) && (Y < 8'(FB_H));
   assign accept    = plot && !full;
   assign push      = accept && in_range;
   assign dbg_state = state;

   // The FIFO is frozen while clearing so pixels drawn after a clear request
   // land on top of the cleared image.
   assign pop    = !rd_req && !clearing && !empty;
   assign clr_wr = !rd_req && clearing;

   pixel_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   ({pixel_addr(X, Y), Colour}),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

`ifdef FB_CLEAR_EN
   assign clearing    = (state == CLEAR);
   assign start_clear = clear_req && (state != CLEAR);
   assign clear_busy  = clearing;
`else
   logic unused_clear;
   assign unused_clear = ^{clear_req, clear_colour};
   assign clearing     = 1'b0;
   assign start_clear  = 1'b0;
   assign clear_busy   = 1'b0;
`endif

   // RAM port owner: read, then clear, then FIFO; idle holds the last address.
   always_comb begin
      mem_we    = pop || clr_wr;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      if (rd_req) begin
         mem_addr = rd_addr;
      end else if (clr_wr) begin
         mem_addr  = clr_addr;
         mem_wdata = clr_colour;
      end else if (pop) begin
         mem_addr  = head[EW-1:COLOUR_W];
         mem_wdata = head[COLOUR_W-1:0];
      end
   end

`ifdef FB_CLEAR_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         clr_addr   <= '0;
         clr_colour <= '0;
         clear_done <= 1'b0;
      end else begin
         clear_done <= 1'b0;
         case (state)
            IDLE, DRAIN: begin
               if (start_clear) begin
                  state      <= CLEAR;
                  clr_addr   <= '0;
                  clr_colour <= clear_colour;
               end else if (state == IDLE && !empty) begin
                  state <= DRAIN;
               end else if (state == DRAIN && empty) begin
                  state <= IDLE;
               end
            end
            CLEAR: begin
               if (clr_wr) begin
                  if (clr_addr == FB_AW'(FB_PIXELS - 1)) begin
                     clr_addr   <= '0;
                     clear_done <= 1'b1;
                     state      <= empty ? IDLE : DRAIN;
                  end else begin
                     clr_addr <= clr_addr + FB_AW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign clr_addr   = '0;
   assign clr_colour = '0;
   assign clear_done = 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (!empty) state <= DRAIN;
            DRAIN:   if (empty)  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid  <= 1'b0;
         rd_data_q <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         clip_cnt  <= '0;
         drop_cnt  <= '0;
      end else begin
         rd_valid <= rd_req;
         if (rd_valid) begin
            rd_data_q <= mem_rdata;
         end
         addr_q  <= mem_addr;
         wdata_q <= mem_wdata;
         if (accept && !in_range && clip_cnt != 16'hFFFF) begin
            clip_cnt <= clip_cnt + 16'd1;
         end
         if (plot && full && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   // RAM data arrives in the rd_valid cycle; the register keeps the last
   // read value visible afterwards.
   assign rd_data = rd_valid ? mem_rdata : rd_data_q;

endmodule

// File: tb/tb_fb_writer.sv
// tb_fb_writer: self-checking bench for fb_writer with a behavioural RAM,
// a reference model (occupancy count, expected write queue, counters,
// clear progress) and a monitor that compares the DUT every cycle.
// Clear scenarios run only when FB_CLEAR_EN is defined.
module tb_fb_writer;
   import fb_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        plot = 1'b0;
   logic [8:0]  X = '0;
   logic [7:0]  Y = '0;
   logic [14:0] Colour = '0;
   logic        ready;
   logic        rd_req = 1'b0;
   logic [16:0] rd_addr = '0;
   logic        rd_valid;
   logic [14:0] rd_data;
   logic [16:0] mem_addr;
   logic [14:0] mem_wdata;
   logic        mem_we;
   logic [14:0] mem_rdata = '0;
   logic        clear_req = 1'b0;
   logic [14:0] clear_colour = '0;
   logic        clear_busy;
   logic        clear_done;
   logic [15:0] clip_cnt;
   logic [15:0] drop_cnt;
   fb_state_t   dbg_state;

   fb_writer #(.FIFO_DEPTH(DEPTH), .COLOUR_W(15)) dut (
      .clk          (clk),
      .reset        (reset),
      .plot         (plot),
      .X            (X),
      .Y            (Y),
      .Colour       (Colour),
      .ready        (ready),
      .rd_req       (rd_req),
      .rd_addr      (rd_addr),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_rdata    (mem_rdata),
      .clear_req    (clear_req),
      .clear_colour (clear_colour),
      .clear_busy   (clear_busy),
      .clear_done   (clear_done),
      .clip_cnt     (clip_cnt),
      .drop_cnt     (drop_cnt),
      .dbg_state    (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- RAM ----------------
   logic [14:0] ram [0:76799];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   // ---------------- scoreboard / model ----------------
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   logic [31:0] exp_q[$];
   int          occ, occ_pre, clip_m, drop_m, clr_next;
   bit          clr_active, was_clr, done_exp, rd_pend;
   logic [14:0] clr_col, rd_exp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         occ = 0; exp_q.delete(); clip_m = 0; drop_m = 0;
         clr_active = 0; done_exp = 0; clr_next = 0; rd_pend = 0;
      end else begin
         occ_pre = occ;
         was_clr = clr_active;
         rd_pend = rd_req;
         if (rd_req) rd_exp = ram[rd_addr];
         done_exp = 0;
         if (!rd_req) begin
            if (was_clr) begin
               if (clr_next == FB_PIXELS - 1) begin
                  clr_active = 0;
                  done_exp = 1;
               end else begin
                  clr_next++;
               end
            end else if (occ_pre > 0) begin
               occ--;
            end
         end
`ifdef FB_CLEAR_EN
         if (!was_clr && clear_req) begin
            clr_active = 1; clr_next = 0; clr_col = clear_colour;
         end
`endif
         if (plot) begin
            if (occ_pre < DEPTH) begin
               if (X < 320 && Y < 240) begin
                  occ++;
                  exp_q.push_back({17'(int'(Y) * 320 + int'(X)), Colour});
               end else if (clip_m < 65535) begin
                  clip_m++;
               end
            end else if (drop_m < 65535) begin
               drop_m++;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [31:0] e;
      if (mon_en) begin
         chk("ready", 32'(ready), 32'(occ < DEPTH));
         chk("mem_we", 32'(mem_we), 32'(!rd_req && (clr_active || occ > 0)));
         if (rd_req) chk("rd_addr_fwd", 32'(mem_addr), 32'(rd_addr));
         if (mem_we) begin
            if (clr_active) begin
               chk("clr_addr", 32'(mem_addr), 32'(clr_next));
               chk("clr_data", 32'(mem_wdata), 32'(clr_col));
            end else if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %0h data %0h with nothing pending", mem_addr, mem_wdata);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 32'(mem_addr), 32'(e[31:15]));
               chk("wr_data", 32'(mem_wdata), 32'(e[14:0]));
            end
         end
         chk("rd_valid", 32'(rd_valid), 32'(rd_pend));
         if (rd_pend) chk("rd_data", 32'(rd_data), 32'(rd_exp));
         chk("clip_cnt", 32'(clip_cnt), 32'(clip_m));
         chk("drop_cnt", 32'(drop_cnt), 32'(drop_m));
         chk("clear_busy", 32'(clear_busy), 32'(clr_active));
         chk("clear_done", 32'(clear_done), 32'(done_exp));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input bit p, input int x, input int y, input int c,
                       input bit rq, input int ra);
      plot = p; X = 9'(x); Y = 8'(y); Colour = 15'(c);
      rd_req = rq; rd_addr = 17'(ra);
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic rand_steps(input int n, input int plot_pct, input int rd_pct);
      for (int i = 0; i < n; i++)
         step($urandom_range(0, 99) < plot_pct, $urandom_range(0, 340),
              $urandom_range(0, 250), $urandom_range(0, 32767),
              $urandom_range(0, 99) < rd_pct, $urandom_range(0, 76799));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      for (int i = 0; i < 76800; i++) ram[i] = 15'(i * 7 + 3);
      reset = 1'b1;
      @(posedge clk);
      #2;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      chk("reset_mem_addr", 32'(mem_addr), 32'd0);
      chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("reset_rd_data", 32'(rd_data), 32'd0);

      // simple write: 2*320+5 = 645 on the next cycle
      step(1, 5, 2, 'h7FFF, 0, 0);
      chk("simple_we", 32'(mem_we), 32'd1);
      chk("simple_addr", 32'(mem_addr), 32'd645);
      idle(3);

      // clipping edges
      step(1, 320, 0, 1, 0, 0);
      step(1, 0, 240, 2, 0, 0);
      step(1, 319, 239, 'h1234, 0, 0);
      chk("edge_addr", 32'(mem_addr), 32'd76799);
      idle(3);
      chk("clip_direct", 32'(clip_cnt), 32'd2);

      // backpressure: reads hold the port while six pixels arrive
      for (int i = 0; i < 6; i++) step(1, i, 10, 100 + i, 1, $urandom_range(0, 76799));
      idle(6);
      chk("drop_direct", 32'(drop_cnt), 32'd2);

      // read priority over a pending pixel
      step(1, 7, 7, 'h55, 0, 0);
      step(0, 0, 0, 0, 1, 1000);
      chk("rd_prio_data", 32'(rd_data), 32'(15'(1000 * 7 + 3)));
      idle(3);

      // randomized traffic, light and heavy read load
      rand_steps(3000, 60, 25);
      rand_steps(600, 80, 70);
      idle(10);

`ifdef FB_CLEAR_EN
      // full clear with a pixel pushed and a second clear request mid-clear
      clear_req = 1'b1; clear_colour = 15'h001F;
      step(0, 0, 0, 0, 0, 0);
      clear_req = 1'b0;
      cyc = 1;
      while (!clear_done && cyc < 80000) begin
         if (cyc == 100) step(1, 9, 9, 'h2AA, 0, 0);
         else if (cyc == 200) begin
            clear_req = 1'b1; clear_colour = 15'h7C00;
            step(0, 0, 0, 0, 0, 0);
            clear_req = 1'b0;
         end else step(0, 0, 0, 0, 0, 0);
         cyc++;
      end
      chk("clear_len", 32'(cyc), 32'd76801);
      idle(5);
      chk("drained_after_clear", 32'(exp_q.size()), 32'd0);

      // reset in the middle of a clear
      clear_req = 1'b1; clear_colour = 15'h03E0;
      step(0, 0, 0, 0, 0, 0);
      clear_req = 1'b0;
      step(1, 3, 3, 'h111, 0, 0);
      idle(998);
      reset = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      chk("busy_after_reset", 32'(clear_busy), 32'd0);
      chk("ready_after_reset", 32'(ready), 32'd1);
      idle(20);
`endif

      idle(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
